// File: rtl/lsu.sv
// lsu: load/store stage between execute and writeback.
// Accepts one memory operation per valid/ready handshake and issues it to the
// data RAM. It then returns the extended load result, or 0, to writeback.
// Optional feature: define LSU_MISALIGN_CHK_EN to flag misaligned H/W accesses
// through o_lsu_err and suppress their RAM request.
module lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sys_valid,
  output logic                  o_sys_ready,
  input  logic                  i_idu_ctr_ram_rd_en,
  input  logic                  i_idu_ctr_ram_wr_en,
  input  logic [2:0]            i_idu_ctr_ram_byt,
  input  logic [ADDR_WIDTH-1:0] i_exu_res,
  input  logic [DATA_WIDTH-1:0] i_gpr_rd_data,
  output logic                  o_ram_rd_en,
  output logic                  o_ram_wr_en,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wr_data,
  output logic [3:0]            o_ram_wr_mask,
  input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
  input  logic                  i_ram_ack,
  output logic                  o_sys_valid,
  input  logic                  i_sys_ready,
  output logic [DATA_WIDTH-1:0] o_ram_res,
  output logic                  o_lsu_err
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("lsu: DATA_WIDTH must be 32");
  end

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    ld_q, st_q;
  logic [2:0]              byt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   res_q;
  logic                    mem_in;
  logic                    mis_in;

  // Size decode: 000/100 byte, 001/101 halfword, every other code word.
  function automatic logic is_byte(input logic [2:0] byt);
    return (byt[1:0] == 2'b00) && !(byt == 3'b010);
  endfunction

  function automatic logic is_half(input logic [2:0] byt);
    return (byt[1:0] == 2'b01);
  endfunction

  // Byte-lane strobes for the addressed byte/halfword/word.
  function automatic logic [3:0] lane_mask(input logic [2:0] byt, input logic [1:0] off);
    if (is_byte(byt))      return 4'b0001 << off;
    else if (is_half(byt)) return 4'b0011 << {off[1], 1'b0};
    else                   return 4'b1111;
  endfunction

  // Replicate store data across all lanes; the mask selects the live ones.
  function automatic logic [31:0] lane_data(input logic [2:0] byt, input logic [31:0] d);
    if (is_byte(byt))      return {4{d[7:0]}};
    else if (is_half(byt)) return {2{d[15:0]}};
    else                   return d;
  endfunction

  // Pull the addressed lane down to bit 0 and sign- or zero-extend it.
  function automatic logic [31:0] load_ext(input logic [2:0] byt, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [31:0] sb, sh;
    sb = rd >> {off, 3'b000};
    sh = rd >> {off[1], 4'b0000};
    if (is_byte(byt))      return byt[2] ? {24'h0, sb[7:0]}  : {{24{sb[7]}}, sb[7:0]};
    else if (is_half(byt)) return byt[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
    else                   return rd;
  endfunction

  assign mem_in = i_idu_ctr_ram_rd_en | i_idu_ctr_ram_wr_en;

`ifdef LSU_MISALIGN_CHK_EN
  logic err_q;

  // Misaligned H/W memory ops skip the RAM and report through o_lsu_err.
  always_comb begin
    mis_in = 1'b0;
    if (mem_in) begin
      if (is_half(i_idu_ctr_ram_byt))
        mis_in = i_exu_res[0];
      else if (!is_byte(i_idu_ctr_ram_byt))
        mis_in = (i_exu_res[1:0] != 2'b00);
    end
  end

  // Error flag: set on acceptance of a misaligned op, cleared when DONE hands off.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      err_q <= 1'b0;
    else if (state_q == IDLE && i_sys_valid)
      err_q <= mis_in;
    else if (state_q == DONE && i_sys_ready)
      err_q <= 1'b0;
  end

  assign o_lsu_err = err_q;
`else
  assign mis_in    = 1'b0;
  assign o_lsu_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and state-decoded outputs; RAM request is live only in REQ.
  always_comb begin
    state_d       = state_q;
    o_sys_ready   = 1'b0;
    o_sys_valid   = 1'b0;
    o_ram_rd_en   = 1'b0;
    o_ram_wr_en   = 1'b0;
    o_ram_addr    = '0;
    o_ram_wr_data = '0;
    o_ram_wr_mask = 4'b0000;
    case (state_q)
      IDLE: begin
        o_sys_ready = 1'b1;
        if (i_sys_valid) state_d = (mem_in && !mis_in) ? REQ : DONE;
      end
      REQ: begin
        o_ram_rd_en   = ld_q;
        o_ram_wr_en   = st_q;
        o_ram_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        o_ram_wr_data = lane_data(byt_q, wdata_q);
        o_ram_wr_mask = lane_mask(byt_q, addr_q[1:0]);
        if (i_ram_ack) state_d = DONE;
      end
      DONE: begin
        o_sys_valid = 1'b1;
        if (i_sys_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operation kind; a store wins when both enables are raised.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ld_q <= 1'b0;
      st_q <= 1'b0;
    end else if (state_q == IDLE && i_sys_valid) begin
      ld_q <= i_idu_ctr_ram_rd_en & ~i_idu_ctr_ram_wr_en;
      st_q <= i_idu_ctr_ram_wr_en;
    end
  end

  // Operand capture at acceptance; outputs are gated by state so no reset needed.
  always_ff @(posedge i_clk) begin
    if (state_q == IDLE && i_sys_valid) begin
      byt_q   <= i_idu_ctr_ram_byt;
      addr_q  <= i_exu_res;
      wdata_q <= i_gpr_rd_data;
    end
  end

  // Result register: cleared on acceptance, loaded on a load acknowledge.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      res_q <= '0;
    else if (state_q == IDLE && i_sys_valid)
      res_q <= '0;
    else if (state_q == REQ && i_ram_ack)
      res_q <= ld_q ? load_ext(byt_q, addr_q[1:0], i_ram_rd_data) : '0;
  end

  assign o_ram_res = res_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store stage between the execute stage and the writeback stage. Accepts one memory operation at a time through a valid/ready handshake. Issues the operation to the data RAM port and waits for the acknowledge. For loads, it extracts the addressed byte, halfword or word and sign- or zero-extends it, then presents the result to writeback as the memory result under a second valid/ready handshake.

## Interface
- DATA_WIDTH, `DATA_WIDTH (32): datapath width; only 32 is supported, any other value is an elaboration error
- ADDR_WIDTH, `ADDR_WIDTH (32): RAM address width
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_sys_valid  in  1  execute stage presents an operation
- o_sys_ready  out  1  LSU can accept an operation
- i_idu_ctr_ram_rd_en  in  1  operation is a load
- i_idu_ctr_ram_wr_en  in  1  operation is a store (takes priority if both are high)
- i_idu_ctr_ram_byt  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes act as W
- i_exu_res  in  ADDR_WIDTH  effective address
- i_gpr_rd_data  in  DATA_WIDTH  store data (rs2)
- o_ram_rd_en  out  1  RAM read request
- o_ram_wr_en  out  1  RAM write request
- o_ram_addr  out  ADDR_WIDTH  word-aligned address ({addr[ADDR_WIDTH-1:2], 2'b00})
- o_ram_wr_data  out  DATA_WIDTH  lane-shifted store data
- o_ram_wr_mask  out  4  byte-lane write strobes
- i_ram_rd_data  in  DATA_WIDTH  RAM read data, valid with i_ram_ack
- i_ram_ack  in  1  RAM completes the current request
- o_sys_valid  out  1  result valid toward writeback
- i_sys_ready  in  1  writeback accepts the result
- o_ram_res  out  DATA_WIDTH  extended load result; 0 for stores and non-memory operations
- o_lsu_err  out  1  misaligned access flag (only with LSU_MISALIGN_CHK_EN)

## Operation
- FSM with three states:
  - IDLE: o_sys_ready=1. On i_sys_valid, register op, size, address and store data.
    - If the op is a load or store, go to REQ.
    - If it is neither, go to DONE with o_ram_res=0.
  - REQ: hold o_ram_rd_en or o_ram_wr_en, plus address, data and mask, stable until i_ram_ack. On ack:
    - Load: register the extended i_ram_rd_data into o_ram_res.
    - Store: set o_ram_res=0.
    - Go to DONE.
  - DONE: o_sys_valid=1 and o_ram_res is held. On i_sys_ready, go to IDLE.
- Byte offset off=addr[1:0].
  - B/BU: mask=1<<off; wdata={4{data[7:0]}}; load takes byte lane off.
  - H/HU: mask=3<<{addr[1],1'b0}; wdata={2{data[15:0]}}; addr[0] is ignored.
  - W: mask=4'hF; addr[1:0] is ignored.
- Load extension:
  - B and H sign-extend from bit 7 or bit 15.
  - BU and HU zero-extend.
- RAM request outputs are 0 in every state except REQ.

## Timing
- Reset state (cycle after i_rst sampled high):
  - FSM is in IDLE.
  - o_sys_ready=1.
  - o_sys_valid=0, o_ram_rd_en=0, o_ram_wr_en=0.
  - o_ram_addr, o_ram_wr_data, o_ram_wr_mask, o_ram_res and o_lsu_err are all 0.
- Handshake:
  - A transfer occurs when valid and ready are both high at a rising edge.
  - o_sys_ready and o_sys_valid are decoded from state only, never combinationally from the peer's valid/ready.
- Latency: accept at edge N, request visible in cycle N+1.
  - If ack arrives in the same cycle, o_sys_valid is high in cycle N+2.
  - Each wait cycle adds one cycle.
- Non-memory op: o_sys_valid is high in cycle N+1.
- Writeback stall: o_sys_valid and o_ram_res stay stable indefinitely until i_sys_ready. No new operation is accepted meanwhile; throughput is at most one op per 2 cycles.
- i_ram_ack outside REQ is ignored.
- Reset mid-operation:
  - Any state returns to IDLE; an outstanding request is dropped and a late ack is ignored.
  - The RAM side must tolerate an abandoned request.

## Configuration
- LSU_MISALIGN_CHK_EN defined:
  - H/HU with addr[0]=1, or W with addr[1:0]!=0, is misaligned.
  - A misaligned op goes IDLE->DONE with no RAM request (store data is not written).
  - In DONE: o_ram_res=0 and o_lsu_err=1. o_lsu_err is held with o_sys_valid and cleared on leaving DONE.
- LSU_MISALIGN_CHK_EN not defined:
  - o_lsu_err is tied to 0.
  - Misaligned accesses are silently truncated to the aligned lane as described above.

## Test plan
- LW: addr 0x100, RAM returns 0x8765_4321 with ack in the request cycle -> o_ram_addr=0x100; o_ram_res=0x8765_4321 two cycles after accept.
- LB / LBU: addr 0x103, RAM data 0x80FF_FF7F -> LB gives 0xFFFF_FF80; LBU gives 0x0000_0080.
- SH: addr 0x202, rs2=0xDEAD_BEEF -> o_ram_wr_mask=4'b1100, o_ram_wr_data=0xBEEF_BEEF, o_ram_addr=0x200; after ack, o_ram_res=0.
- Ack delayed 3 cycles, then writeback stalls 2 cycles -> request signals stable 4 cycles; o_sys_valid high 3 cycles; o_sys_ready stays 0 throughout.
- i_rst pulsed while in REQ -> next cycle o_ram_rd_en=0 and o_sys_ready=1; a subsequent ack produces no o_sys_valid.
- With LSU_MISALIGN_CHK_EN, LW at addr 0x102 -> no o_ram_rd_en; one cycle later o_sys_valid=1, o_lsu_err=1, o_ram_res=0.
